// File: rtl/median_window_gen_if.sv
// Pixel stream in / 3x3 window out bundle for the median window generator.
// The master side is the pixel source plus window consumer; the slave side is
// the window generator itself.
interface median_window_gen_if #(
  parameter int n     = 8,
  parameter int IMG_W = 16,
  parameter int IMG_H = 16
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic          pix_valid;
  logic [n-1:0]  pix_in;
  logic [n-1:0]  w1, w2, w3, w4, w5, w6, w7, w8, w9;
  logic          win_valid;
  logic [RW-1:0] cen_row;
  logic [CW-1:0] cen_col;
  logic          frame_done;

  modport master (
    output pix_valid, pix_in,
    input  w1, w2, w3, w4, w5, w6, w7, w8, w9,
    input  win_valid, cen_row, cen_col, frame_done
  );

  modport slave (
    input  pix_valid, pix_in,
    output w1, w2, w3, w4, w5, w6, w7, w8, w9,
    output win_valid, cen_row, cen_col, frame_done
  );
endinterface

// File: rtl/median_window_gen.sv
// Streaming 3x3 neighbourhood generator. Raster pixels come in one per valid
// cycle; two line buffers hold the previous two rows so that each accepted
// pixel completes a new right-hand window column. A window is flagged valid
// only when all nine taps belong to the current frame.
module median_window_gen #(
  parameter int n     = 8,
  parameter int IMG_W = 16,
  parameter int IMG_H = 16
) (
  input  logic               clk,
  input  logic               reset,
  median_window_gen_if.slave bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  // FILL1 = row 0, FILL2 = row 1, STREAM = rows 2..IMG_H-1.
  typedef enum logic [1:0] {
    FILL1  = 2'd0,
    FILL2  = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_col, w_col_next;
  logic [RW-1:0] r_row, w_row_next;
  logic          w_col_wrap, w_row_wrap;
  logic          w_win_fire, w_frame_end;

  // Line buffers: lb_a holds row r-1, lb_b holds row r-2, indexed by column.
  logic [n-1:0]  r_lb_a [IMG_W];
  logic [n-1:0]  r_lb_b [IMG_W];

  logic [n-1:0]  w_new_col [3];
  logic [n-1:0]  w_win [9];

  logic          r_win_valid;
  logic          r_frame_done;
  logic [RW-1:0] r_cen_row;
  logic [CW-1:0] r_cen_col;

  assign w_col_wrap = (r_col == COL_LAST);
  assign w_row_wrap = (r_row == ROW_LAST);

  // Next position, fill phase, and the window/frame events of this pixel.
  always_comb begin
    w_state_next = r_state;
    w_col_next   = r_col;
    w_row_next   = r_row;
    w_win_fire   = 1'b0;
    w_frame_end  = 1'b0;
    if (bus.pix_valid) begin
      w_col_next = w_col_wrap ? '0 : r_col + COL_ONE;
      if (w_col_wrap) begin
        w_row_next = w_row_wrap ? '0 : r_row + ROW_ONE;
        case (r_state)
          FILL1:   w_state_next = FILL2;
          FILL2:   w_state_next = STREAM;
          STREAM:  w_state_next = w_row_wrap ? FILL1 : STREAM;
          default: w_state_next = FILL1;
        endcase
      end
      // Columns 0/1 would pull taps from the previous line, so they never fire.
      w_win_fire  = (r_state == STREAM) && (r_col >= COL_TWO);
      w_frame_end = w_col_wrap && w_row_wrap;
    end
  end

  // Position counters and fill-phase register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FILL1;
      r_col   <= '0;
      r_row   <= '0;
    end else begin
      r_state <= w_state_next;
      r_col   <= w_col_next;
      r_row   <= w_row_next;
    end
  end

  // Line buffer update; contents survive reset since stale data never fires.
  always_ff @(posedge clk) begin
    if (!reset && bus.pix_valid) begin
      r_lb_b[r_col] <= r_lb_a[r_col];
      r_lb_a[r_col] <= bus.pix_in;
    end
  end

  // New rightmost window column: two rows up, one row up, incoming pixel.
  always_comb begin
    w_new_col[0] = r_lb_b[r_col];
    w_new_col[1] = r_lb_a[r_col];
    w_new_col[2] = bus.pix_in;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_row
      logic [n-1:0] r_tap [3];

      // Shift this window row left and load its new rightmost pixel.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_tap[0] <= '0;
          r_tap[1] <= '0;
          r_tap[2] <= '0;
        end else if (bus.pix_valid) begin
          r_tap[0] <= r_tap[1];
          r_tap[1] <= r_tap[2];
          r_tap[2] <= w_new_col[gi];
        end
      end

      assign w_win[3*gi]     = r_tap[0];
      assign w_win[3*gi + 1] = r_tap[1];
      assign w_win[3*gi + 2] = r_tap[2];
    end
  endgenerate

  // Registered strobes and centre coordinates; coordinates hold between windows.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_cen_row    <= '0;
      r_cen_col    <= '0;
    end else begin
      r_win_valid  <= w_win_fire;
      r_frame_done <= w_frame_end;
      if (w_win_fire) begin
        r_cen_row <= r_row - ROW_ONE;
        r_cen_col <= r_col - COL_ONE;
      end
    end
  end

  assign bus.w1         = w_win[0];
  assign bus.w2         = w_win[1];
  assign bus.w3         = w_win[2];
  assign bus.w4         = w_win[3];
  assign bus.w5         = w_win[4];
  assign bus.w6         = w_win[5];
  assign bus.w7         = w_win[6];
  assign bus.w8         = w_win[7];
  assign bus.w9         = w_win[8];
  assign bus.win_valid  = r_win_valid;
  assign bus.frame_done = r_frame_done;
  assign bus.cen_row    = r_cen_row;
  assign bus.cen_col    = r_cen_col;
endmodule

// File: tb/tb_median_window_gen.sv
// Bench for median_window_gen: a 4x4 instance (env 0) and a 5x3 instance
// (env 1). The driver records every accepted pixel in a flat history and, for
// each pixel that completes a window or a frame, pushes the expected event
// (window taps picked straight out of the history) into a per-env queue. A
// monitor per env pops and compares whenever the DUT raises an event.
module tb_median_window_gen;
  localparam int AW = 4;
  localparam int AH = 4;
  localparam int BW = 5;
  localparam int BH = 3;

  typedef struct packed {
    logic [8:0][7:0] w;
    logic [7:0]      crow;
    logic [7:0]      ccol;
    logic            wv;
    logic            fd;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;

  median_window_gen_if #(.n(8), .IMG_W(AW), .IMG_H(AH)) if_a ();
  median_window_gen_if #(.n(8), .IMG_W(BW), .IMG_H(BH)) if_b ();

  median_window_gen #(.n(8), .IMG_W(AW), .IMG_H(AH)) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (if_a)
  );

  median_window_gen #(.n(8), .IMG_W(BW), .IMG_H(BH)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (if_b)
  );

  int checks = 0;
  int errors = 0;

  int hist [2][0:4095];
  int nacc [2];
  int prow [2];
  int pcol [2];
  int exp_nwv [2];
  int exp_nfd [2];
  int got_nwv [2];
  int got_nfd [2];
  ev_t q_a [$];
  ev_t q_b [$];

  function automatic int width_of(int e);
    return (e == 0) ? AW : BW;
  endfunction

  function automatic int height_of(int e);
    return (e == 0) ? AH : BH;
  endfunction

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ev_t snap(int e);
    ev_t s;
    if (e == 0) begin
      s.w    = {if_a.w9, if_a.w8, if_a.w7, if_a.w6, if_a.w5,
                if_a.w4, if_a.w3, if_a.w2, if_a.w1};
      s.crow = 8'(if_a.cen_row);
      s.ccol = 8'(if_a.cen_col);
      s.wv   = if_a.win_valid;
      s.fd   = if_a.frame_done;
    end else begin
      s.w    = {if_b.w9, if_b.w8, if_b.w7, if_b.w6, if_b.w5,
                if_b.w4, if_b.w3, if_b.w2, if_b.w1};
      s.crow = 8'(if_b.cen_row);
      s.ccol = 8'(if_b.cen_col);
      s.wv   = if_b.win_valid;
      s.fd   = if_b.frame_done;
    end
    return s;
  endfunction

  // Reference model: record the pixel and, if it completes a window or the
  // frame, queue the expected event with taps drawn from the raster history.
  task automatic model_accept(int e, int pix);
    int  wd, ht, k;
    bit  win, last;
    ev_t ev;
    wd = width_of(e);
    ht = height_of(e);
    k  = nacc[e];
    hist[e][k] = pix;
    nacc[e]++;
    win  = (prow[e] >= 2) && (pcol[e] >= 2);
    last = (prow[e] == ht - 1) && (pcol[e] == wd - 1);
    if (win || last) begin
      ev = '0;
      ev.wv = win;
      ev.fd = last;
      if (win) begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            ev.w[r*3 + c] = 8'(hist[e][k - (2 - r)*wd - (2 - c)]);
        ev.crow = 8'(prow[e] - 1);
        ev.ccol = 8'(pcol[e] - 1);
        exp_nwv[e]++;
      end
      if (last) exp_nfd[e]++;
      if (e == 0) q_a.push_back(ev);
      else        q_b.push_back(ev);
    end
    pcol[e]++;
    if (pcol[e] == wd) begin
      pcol[e] = 0;
      prow[e]++;
      if (prow[e] == ht) prow[e] = 0;
    end
  endtask

  task automatic check_ev(int e, ev_t got);
    ev_t exp;
    string tag;
    tag = (e == 0) ? "a" : "b";
    if (got.wv === 1'b1) got_nwv[e]++;
    if (got.fd === 1'b1) got_nfd[e]++;
    if ((e == 0 && q_a.size() == 0) || (e == 1 && q_b.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL %s_unexpected_event win_valid=%0b frame_done=%0b expected none at %0t",
               tag, got.wv, got.fd, $time);
    end else begin
      exp = (e == 0) ? q_a.pop_front() : q_b.pop_front();
      cmp({tag, "_win_valid"}, 32'(got.wv), 32'(exp.wv));
      cmp({tag, "_frame_done"}, 32'(got.fd), 32'(exp.fd));
      if (exp.wv) begin
        for (int i = 0; i < 9; i++)
          cmp($sformatf("%s_w%0d", tag, i + 1), 32'(got.w[i]), 32'(exp.w[i]));
        cmp({tag, "_cen_row"}, 32'(got.crow), 32'(exp.crow));
        cmp({tag, "_cen_col"}, 32'(got.ccol), 32'(exp.ccol));
      end
    end
  endtask

  // Monitors: act only when the DUT presents a window or frame event.
  always @(negedge clk) begin
    if (if_a.win_valid === 1'b1 || if_a.frame_done === 1'b1) check_ev(0, snap(0));
  end

  always @(negedge clk) begin
    if (if_b.win_valid === 1'b1 || if_b.frame_done === 1'b1) check_ev(1, snap(1));
  end

  task automatic send(int e, bit v, int pix);
    @(posedge clk);
    #1;
    if (e == 0) begin
      if_a.pix_valid = v;
      if_a.pix_in    = 8'(pix);
    end else begin
      if_b.pix_valid = v;
      if_b.pix_in    = 8'(pix);
    end
    if (v) model_accept(e, pix);
  endtask

  // mode 0: continuous, 1: valid toggling 1,0, 2: random pixels with random gaps
  task automatic frame(int e, int mode, int offs);
    int pix;
    for (int r = 0; r < height_of(e); r++) begin
      for (int c = 0; c < width_of(e); c++) begin
        pix = (mode == 2) ? int'($urandom_range(0, 255)) : (r*16 + c + offs);
        if (mode == 2) begin
          while ($urandom_range(0, 2) == 0) send(e, 1'b0, 0);
        end
        send(e, 1'b1, pix);
        if (mode == 1) send(e, 1'b0, 0);
      end
    end
  endtask

  task automatic drain(int e, string name);
    send(e, 1'b0, 0);
    repeat (4) @(posedge clk);
    #1;
    cmp({name, "_queue_left"}, 32'((e == 0) ? q_a.size() : q_b.size()), 32'd0);
    cmp({name, "_win_count"}, 32'(got_nwv[e]), 32'(exp_nwv[e]));
    cmp({name, "_done_count"}, 32'(got_nfd[e]), 32'(exp_nfd[e]));
  endtask

  // Reset, optionally with pix_valid high in the same cycle, then check that
  // every output is zero on the cycle after.
  task automatic reset_dut(int e, bit with_pix);
    ev_t s;
    string tag;
    tag = (e == 0) ? "a" : "b";
    @(posedge clk);
    #1;
    if (e == 0) begin
      rst_a = 1'b1; if_a.pix_valid = with_pix; if_a.pix_in = 8'h5A;
    end else begin
      rst_b = 1'b1; if_b.pix_valid = with_pix; if_b.pix_in = 8'h5A;
    end
    @(posedge clk);
    #1;
    if (e == 0) begin
      rst_a = 1'b0; if_a.pix_valid = 1'b0;
    end else begin
      rst_b = 1'b0; if_b.pix_valid = 1'b0;
    end
    prow[e] = 0;
    pcol[e] = 0;
    @(negedge clk);
    s = snap(e);
    for (int i = 0; i < 9; i++)
      cmp($sformatf("%s_reset_w%0d", tag, i + 1), 32'(s.w[i]), 32'd0);
    cmp({tag, "_reset_win_valid"}, 32'(s.wv), 32'd0);
    cmp({tag, "_reset_frame_done"}, 32'(s.fd), 32'd0);
    cmp({tag, "_reset_cen_row"}, 32'(s.crow), 32'd0);
    cmp({tag, "_reset_cen_col"}, 32'(s.ccol), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish, checks so far %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int e = 0; e < 2; e++) begin
      nacc[e] = 0; prow[e] = 0; pcol[e] = 0;
      exp_nwv[e] = 0; exp_nfd[e] = 0; got_nwv[e] = 0; got_nfd[e] = 0;
    end
    rst_a = 1'b1;
    rst_b = 1'b1;
    if_a.pix_valid = 1'b0; if_a.pix_in = '0;
    if_b.pix_valid = 1'b0; if_b.pix_in = '0;
    repeat (2) @(posedge clk);
    reset_dut(0, 1'b0);
    reset_dut(1, 1'b0);

    // 4x4 pattern frame, continuous
    frame(0, 0, 0);
    drain(0, "a_cont");
    cmp("a_cont_windows", 32'(got_nwv[0]), 32'd4);

    // same frame with valid toggling
    frame(0, 1, 0);
    drain(0, "a_toggle");
    cmp("a_toggle_windows", 32'(got_nwv[0]), 32'd8);

    // two back-to-back frames, second offset by 0x80
    frame(0, 0, 0);
    frame(0, 0, 'h80);
    drain(0, "a_b2b");
    cmp("a_b2b_windows", 32'(got_nwv[0]), 32'd16);

    // reset together with pix_valid after 9 pixels, then a fresh frame
    for (int i = 0; i < 9; i++) send(0, 1'b1, (i / AW)*16 + (i % AW));
    reset_dut(0, 1'b1);
    frame(0, 0, 0);
    drain(0, "a_midreset");
    cmp("a_midreset_windows", 32'(got_nwv[0]), 32'd20);

    // random pixels and gaps over several frames
    for (int f = 0; f < 4; f++) frame(0, 2, 0);
    drain(0, "a_random");

    // 5x3 pattern frame, then random frames
    frame(1, 0, 0);
    drain(1, "b_cont");
    cmp("b_cont_windows", 32'(got_nwv[1]), 32'd3);
    cmp("b_cont_done", 32'(got_nfd[1]), 32'd1);
    for (int f = 0; f < 3; f++) frame(1, 2, 0);
    drain(1, "b_random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
